conv_bias_add_ctrl: RTL and testbench

//  Sequences the per-channel bias stage of a conv layer. Takes raw MAC

---
 rtl/conv_bias_add_ctrl.sv | 132 +++++++++++++
 tb/tb_conv_bias_add_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_bias_add_ctrl.sv
// Per-channel bias stage for a conv layer: latches a MAC accumulator with its
// channel bias, then adds, rounds half-up and saturates to Q1.7 for downstream.
module conv_bias_add_ctrl #(
    parameter int NUM_CH   = 16,
    parameter int NUM_PIX  = 1024,
    parameter int ACC_W    = 24,
    parameter int ACC_FRAC = 14,
    parameter int RELU     = 0,
    localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [ACC_W-1:0] in_acc,
    output logic        [15:0]      rom_row,
    output logic        [15:0]      rom_col,
    input  logic signed [7:0]       rom_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [7:0]       out_data,
    output logic        [CH_W-1:0]  out_ch,
    output logic                    busy,
    output logic                    done
);

    localparam int PIX_W = (NUM_PIX > 1) ? $clog2(NUM_PIX) : 1;
    localparam int SUM_W = ACC_W + 2;
    localparam int SHIFT = ACC_FRAC - 7;
    localparam logic signed [SUM_W-1:0] RND     = SUM_W'(1) <<< (SHIFT - 1);
    localparam logic signed [SUM_W-1:0] SAT_MAX = SUM_W'(127);
    localparam logic signed [SUM_W-1:0] SAT_MIN = SUM_W'(-128);

    typedef enum logic [1:0] {S_IDLE, S_WAIT_IN, S_CALC, S_OUT} state_t;

    state_t                   state_reg, state_next;
    logic        [CH_W-1:0]   ch_cnt_reg;
    logic        [PIX_W-1:0]  pix_cnt_reg;
    logic signed [ACC_W-1:0]  acc_reg;
    logic signed [7:0]        bias_reg;

    logic                     in_hs, out_hs, last_ch, last_item;
    logic signed [SUM_W-1:0]  acc_ext, bias_ext, sum_c, rnd_c;
    logic signed [7:0]        sat_c, res_c;

    assign in_hs     = in_valid & in_ready;
    assign out_hs    = out_valid & out_ready;
    assign last_ch   = (ch_cnt_reg == CH_W'(NUM_CH - 1));
    assign last_item = last_ch && (pix_cnt_reg == PIX_W'(NUM_PIX - 1));

    assign rom_row = 16'(ch_cnt_reg);
    assign rom_col = 16'd0;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:    if (start)  state_next = S_WAIT_IN;
            S_WAIT_IN: if (in_hs)  state_next = S_CALC;
            S_CALC:                state_next = S_OUT;
            S_OUT:     if (out_hs) state_next = last_item ? S_IDLE : S_WAIT_IN;
            default:               state_next = S_IDLE;
        endcase
    end

    // Handshake and status outputs follow the state directly
    always_comb begin
        in_ready  = (state_reg == S_WAIT_IN);
        out_valid = (state_reg == S_OUT);
        busy      = (state_reg != S_IDLE);
    end

    // Bias is aligned to the accumulator's binary point before the add
    always_comb begin
        acc_ext  = {{2{acc_reg[ACC_W-1]}}, acc_reg};
        bias_ext = {{(SUM_W-8){bias_reg[7]}}, bias_reg};
        sum_c    = acc_ext + (bias_ext <<< SHIFT);
        rnd_c    = (sum_c + RND) >>> SHIFT;
        if (rnd_c > SAT_MAX) begin
            sat_c = 8'sh7f;
        end else if (rnd_c < SAT_MIN) begin
            sat_c = 8'sh80;
        end else begin
            sat_c = rnd_c[7:0];
        end
        res_c = ((RELU != 0) && sat_c[7]) ? 8'sh00 : sat_c;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_reg     <= '0;
            bias_reg    <= '0;
            ch_cnt_reg  <= '0;
            pix_cnt_reg <= '0;
            out_data    <= '0;
            out_ch      <= '0;
            done        <= 1'b0;
        end else begin
            done <= out_hs && last_item;
            if (in_hs) begin
                acc_reg  <= in_acc;
                bias_reg <= rom_data;
            end
            if (state_reg == S_CALC) begin
                out_data <= res_c;
                out_ch   <= ch_cnt_reg;
            end
            if (out_hs) begin
                if (last_item) begin
                    ch_cnt_reg  <= '0;
                    pix_cnt_reg <= '0;
                end else if (last_ch) begin
                    ch_cnt_reg  <= '0;
                    pix_cnt_reg <= pix_cnt_reg + 1'b1;
                end else begin
                    ch_cnt_reg  <= ch_cnt_reg + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_conv_bias_add_ctrl.sv
// Randomized bench for conv_bias_add_ctrl: plain-arithmetic reference model,
// scoreboard queue and per-cycle output comparison for a plain and a RELU instance.
module tb_conv_bias_add_ctrl;

    localparam int NUM_CH   = 16;
    localparam int NUM_PIX  = 2;
    localparam int ACC_W    = 24;
    localparam int ACC_FRAC = 14;
    localparam int SH       = ACC_FRAC - 7;
    localparam int ITEMS    = NUM_CH * NUM_PIX;
    localparam int NOLIT    = -999;

    typedef struct {
        int d;
        int dr;
        int ch;
    } exp_t;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    start = 1'b0;
    logic                    in_valid = 1'b0;
    logic signed [ACC_W-1:0] in_acc = '0;
    logic                    out_ready = 1'b0;

    logic                    in_ready, out_valid, busy, done;
    logic        [15:0]      rom_row, rom_col;
    logic signed [7:0]       rom_data, out_data;
    logic        [3:0]       out_ch;

    logic                    in_ready_r, out_valid_r, busy_r, done_r;
    logic        [15:0]      rom_row_r, rom_col_r;
    logic signed [7:0]       rom_data_r, out_data_r;
    logic        [3:0]       out_ch_r;

    logic signed [7:0] bias_rom [NUM_CH];
    exp_t q[$];
    int   cmp_total = 0;
    int   cmp_bad   = 0;
    int   item_idx  = 0;
    int   done_cnt  = 0;

    assign rom_data   = bias_rom[rom_row[3:0]];
    assign rom_data_r = bias_rom[rom_row_r[3:0]];

    always #5 clk = ~clk;

    conv_bias_add_ctrl #(.NUM_CH(NUM_CH), .NUM_PIX(NUM_PIX), .ACC_W(ACC_W),
                         .ACC_FRAC(ACC_FRAC), .RELU(0)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
        .in_ready(in_ready), .in_acc(in_acc), .rom_row(rom_row), .rom_col(rom_col),
        .rom_data(rom_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_ch(out_ch), .busy(busy), .done(done));

    conv_bias_add_ctrl #(.NUM_CH(NUM_CH), .NUM_PIX(NUM_PIX), .ACC_W(ACC_W),
                         .ACC_FRAC(ACC_FRAC), .RELU(1)) dut_r (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
        .in_ready(in_ready_r), .in_acc(in_acc), .rom_row(rom_row_r), .rom_col(rom_col_r),
        .rom_data(rom_data_r), .out_valid(out_valid_r), .out_ready(out_ready),
        .out_data(out_data_r), .out_ch(out_ch_r), .busy(busy_r), .done(done_r));

    task automatic check(input string name, input int act, input int exp_v);
        cmp_total++;
        if (act != exp_v) begin
            cmp_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
        end
    endtask

    // Real-valued intent: floor((acc + bias*2^S)/2^S + 1/2), clamp to int8, optional ReLU.
    function automatic int model(input int acc, input int bias, input bit relu);
        longint scale, num, fl;
        scale = longint'(1) << SH;
        num   = longint'(acc) + longint'(bias) * scale + scale / 2;
        if (num >= 0) fl = num / scale;
        else          fl = -((-num + scale - 1) / scale);
        if (fl > 127)  fl = 127;
        if (fl < -128) fl = -128;
        if (relu && fl < 0) fl = 0;
        return int'(fl);
    endfunction

    function automatic int rand_acc();
        int v;
        v = $signed($urandom) >>> $urandom_range(8, 16);
        return v;
    endfunction

    // Per-cycle comparison against the scoreboard head
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid) begin
                if (q.size() == 0) begin
                    check("unexpected_out_valid", 1, 0);
                end else begin
                    check("out_data", out_data, q[0].d);
                    check("out_ch", out_ch, q[0].ch);
                    check("relu_out_data", out_data_r, q[0].dr);
                    check("in_ready_during_out", in_ready, 0);
                end
            end
            check("relu_out_valid", out_valid_r, out_valid);
            check("relu_busy", busy_r, busy);
            check("relu_done", done_r, done);
            if (in_ready) begin
                check("rom_row", rom_row, item_idx % NUM_CH);
                check("rom_col", rom_col, 0);
                check("relu_rom_row", rom_row_r, item_idx % NUM_CH);
                check("relu_rom_col", rom_col_r, 0);
            end
        end
        if (done) done_cnt++;
    end

    always @(posedge clk) begin
        if (rst_n && out_valid && out_ready && q.size() > 0) void'(q.pop_front());
    end

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("start_busy", busy, 1);
        check("start_in_ready", in_ready, 1);
    endtask

    task automatic xfer(input int acc, input int hold, input bit pre, input int lit, input int lit_r);
        int   n;
        int   ch;
        bit   last;
        exp_t e;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check("in_ready_timeout", 0, 1);
            return;
        end
        ch        = item_idx % NUM_CH;
        e.d       = model(acc, bias_rom[ch], 1'b0);
        e.dr      = model(acc, bias_rom[ch], 1'b1);
        e.ch      = ch;
        in_valid  = 1'b1;
        in_acc    = acc[ACC_W-1:0];
        out_ready = pre;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_acc   = ACC_W'($urandom);
        q.push_back(e);
        check("latency_edge1_valid", out_valid, 0);
        @(posedge clk); #1;
        check("latency_edge2_valid", out_valid, 1);
        if (lit != NOLIT)   check("literal_data", out_data, lit);
        if (lit_r != NOLIT) check("literal_relu_data", out_data_r, lit_r);
        if (!pre) begin
            for (int h = 0; h < hold; h++) begin
                @(posedge clk); #1;
                check("hold_out_valid", out_valid, 1);
                check("hold_in_ready", in_ready, 0);
                if (hold >= 5) in_valid = (h < hold - 1);
            end
            in_valid = 1'b0;
            @(negedge clk);
            out_ready = 1'b1;
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
        last = (item_idx == ITEMS - 1);
        check("post_hs_out_valid", out_valid, 0);
        check("post_hs_done", done, int'(last));
        check("post_hs_busy", busy, int'(!last));
        item_idx = last ? 0 : item_idx + 1;
        $display("xfer ch=%0d acc=%0d exp=%0d exp_relu=%0d last=%0d", ch, acc, e.d, e.dr, last);
    endtask

    task automatic rst_mid(input bit in_out);
        do_start();
        @(negedge clk);
        in_valid = 1'b1;
        in_acc   = 24'sd1000;
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (in_out) begin
            @(posedge clk); #1;
            check("pre_reset_out_valid", out_valid, 1);
            check("pre_reset_out_data", out_data, model(1000, bias_rom[0], 1'b0));
        end
        rst_n = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_ch", out_ch, 0);
        q.delete();
        item_idx = 0;
        @(negedge clk);
        rst_n = 1'b1;
        $display("reset mid-frame in_out=%0d", in_out);
    endtask

    task automatic run_frame(input int frame);
        int acc, hold, lit, lit_r;
        bit pre;
        for (int i = 0; i < ITEMS; i++) begin
            acc   = rand_acc();
            hold  = $urandom_range(0, 2);
            pre   = 1'($urandom_range(0, 1));
            lit   = NOLIT;
            lit_r = NOLIT;
            if (frame == 1) begin
                case (i)
                    0:  begin acc = 12800;  lit = 88;   lit_r = 88;  pre = 1'b0; hold = 0; end
                    3:  begin pre = 1'b0; hold = 5; end
                    5:  begin acc = 64;     lit = 1;    lit_r = 1;   end
                    6:  begin acc = 25600;  lit = 127;  lit_r = 127; end
                    16: begin acc = -25600; lit = -128; lit_r = 0;   end
                    21: begin acc = -64;    lit = 0;    lit_r = 0;   end
                    default: ;
                endcase
                if (i == 10) do_start();
            end else if (frame == 2) begin
                if (i == 0) pre = 1'b1;
                if (i == 5) begin acc = 63; lit = 0; lit_r = 0; end
            end
            xfer(acc, hold, pre, lit, lit_r);
        end
    endtask

    initial begin
        for (int c = 0; c < NUM_CH; c++) bias_rom[c] = 8'($urandom);
        bias_rom[0] = -8'sd12;
        bias_rom[5] = 8'sd0;
        bias_rom[6] = 8'sd18;

        #1;
        check("reset_out_valid", out_valid, 0);
        check("reset_in_ready", in_ready, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_out_data", out_data, 0);
        check("reset_out_ch", out_ch, 0);
        check("reset_rom_row", rom_row, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // in_valid while idle must not start anything
        @(negedge clk);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check("idle_ignores_in_valid", busy, 0);

        do_start();
        done_cnt = 0;
        run_frame(1);
        // start on the done cycle is honoured
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("done_cycle_start_busy", busy, 1);
        check("done_pulse_width", done, 0);
        check("frame1_done_count", done_cnt, 1);
        done_cnt = 0;

        run_frame(2);
        @(negedge clk);
        @(negedge clk);
        check("frame2_done_count", done_cnt, 1);
        check("frame2_idle_in_ready", in_ready, 0);
        check("frame2_idle_busy", busy, 0);

        rst_mid(1'b0);
        rst_mid(1'b1);

        do_start();
        done_cnt = 0;
        run_frame(3);
        @(negedge clk);
        @(negedge clk);
        check("frame3_done_count", done_cnt, 1);
        check("frame3_idle_busy", busy, 0);
        check("scoreboard_empty", q.size(), 0);

        $display("test done: total=%0d bad=%0d", cmp_total, cmp_bad);
        $finish;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
